// File: rtl/sha3_squeeze_ctrl_pkg.sv
// Shared types for the SHA3 squeeze controller: strength/rate mapping, sparse FSM
// encoding, mubi4 / lc_tx encodings and the error record.
package sha3_squeeze_ctrl_pkg;

    localparam int StateW        = 1600;
    localparam int WordsPerState = StateW / 32;

    typedef enum logic [2:0] {
        L128 = 3'h0,
        L224 = 3'h1,
        L256 = 3'h2,
        L384 = 3'h3,
        L512 = 3'h4
    } keccak_strength_e;

    typedef logic [3:0] mubi4_t;
    localparam mubi4_t MuBi4True  = 4'h6;
    localparam mubi4_t MuBi4False = 4'h9;

    typedef logic [3:0] lc_tx_t;
    localparam lc_tx_t LcTxOn  = 4'b0101;
    localparam lc_tx_t LcTxOff = 4'b1010;

    // Anything other than a clean Off counts as escalation.
    function automatic logic lc_tx_test_true_loose(lc_tx_t v);
        return v != LcTxOff;
    endfunction

    typedef enum logic [7:0] {
        ErrNone          = 8'h00,
        ErrSha3SwControl = 8'h80
    } err_code_e;

    typedef struct packed {
        logic      valid;
        err_code_e code;
        logic [23:0] info;
    } err_t;

    typedef enum logic [5:0] {
        SqIdle          = 6'b001011,
        SqWaitState     = 6'b110001,
        SqEmit          = 6'b010110,
        SqWaitRun       = 6'b101100,
        SqDone          = 6'b100111,
        SqTerminalError = 6'b011000
    } sha3_sq_st_sparse_e;

    // Number of 32-bit words in the rate block; 0 marks an unsupported strength.
    function automatic logic [5:0] rate_words32(keccak_strength_e s);
        case (s)
            L128:    return 6'd42;
            L224:    return 6'd36;
            L256:    return 6'd34;
            L384:    return 6'd26;
            L512:    return 6'd18;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/sha3_squeeze_ctrl_word_sel.sv
// Per-share 32-bit word selector over the exposed Keccak state; output is zero
// unless enabled so no state bits leak onto the digest bus.
module sha3_squeeze_ctrl_word_sel
    import sha3_squeeze_ctrl_pkg::*;
#(
    parameter int Share = 1
) (
    input  logic [StateW-1:0] state_i [Share],
    input  logic [5:0]        idx_i,
    input  logic              en_i,
    output logic [31:0]       word_o  [Share]
);

    always_comb begin
        for (int s = 0; s < Share; s++) begin
            word_o[s] = '0;
            if (en_i && (idx_i < 6'(WordsPerState))) begin
                word_o[s] = state_i[s][32*idx_i +: 32];
            end
        end
    end

endmodule

// File: rtl/sha3_squeeze_ctrl.sv
// Streams the first N rate words of the squeezing Keccak state as 32-bit digest
// words, requesting extra permutations when a rate block runs out.
module sha3_squeeze_ctrl
    import sha3_squeeze_ctrl_pkg::*;
#(
    parameter bit  EnMasking = 1'b0,
    parameter int  OutLenW   = 16,
    localparam int Share     = EnMasking ? 2 : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  keccak_strength_e  strength_i,
    input  logic [OutLenW-1:0] out_words_i,
    input  logic              state_valid_i,
    input  logic [StateW-1:0] state_i [Share],
    input  logic              block_processed_i,
    output logic              run_o,
    output mubi4_t            done_o,
    output logic              digest_valid_o,
    output logic [31:0]       digest_data_o [Share],
    output logic              digest_last_o,
    input  logic              digest_ready_i,
    output logic              busy_o,
    input  lc_tx_t            lc_escalate_en_i,
    output err_t              error_o,
    output logic              sparse_fsm_error_o
);

    sha3_sq_st_sparse_e st_q;
    keccak_strength_e   strength_q;
    logic [OutLenW-1:0] rem_q;
    logic [5:0]         idx_q;
    err_t               err_q;

    logic       escalate, idx_ok, hs, last_hs, start_ok, start_err, drop_err;
    logic [5:0] rw;

    assign escalate = lc_tx_test_true_loose(lc_escalate_en_i);
    assign rw       = rate_words32(strength_q);
    assign idx_ok   = idx_q < rw;
    assign start_ok = (out_words_i != '0) && (rate_words32(strength_i) != 6'd0);

    // Valid is gated by the live state and escalation so a handshake can never
    // complete on a word the FSM is about to abandon.
    assign digest_valid_o = (st_q == SqEmit) && idx_ok && state_valid_i && !escalate;
    assign digest_last_o  = digest_valid_o && (rem_q == OutLenW'(1));
    assign hs             = digest_valid_o && digest_ready_i;
    assign last_hs        = hs && (rem_q == OutLenW'(1));
    assign run_o          = hs && !last_hs && (idx_q == rw - 6'd1);

    assign start_err = start_i && !escalate &&
                       ((st_q == SqIdle) ? !start_ok : (st_q != SqTerminalError));
    assign drop_err  = (st_q == SqEmit) && idx_ok && !state_valid_i && !escalate;

    assign done_o             = (st_q == SqDone) ? MuBi4True : MuBi4False;
    assign busy_o             = (st_q != SqIdle) && (st_q != SqTerminalError);
    assign sparse_fsm_error_o = (st_q == SqTerminalError);
    assign error_o            = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q       <= SqIdle;
            strength_q <= L128;
            rem_q      <= '0;
            idx_q      <= '0;
            err_q      <= '0;
        end else begin
            err_q.valid <= start_err || drop_err;
            err_q.code  <= (start_err || drop_err) ? ErrSha3SwControl : ErrNone;
            err_q.info  <= {22'd0, drop_err, start_err};
            if (escalate) begin
                st_q  <= SqTerminalError;
                rem_q <= '0;
                idx_q <= '0;
            end else begin
                case (st_q)
                    SqIdle: begin
                        if (start_i && start_ok) begin
                            strength_q <= strength_i;
                            rem_q      <= out_words_i;
                            idx_q      <= '0;
                            st_q       <= SqWaitState;
                        end
                    end
                    SqWaitState: if (state_valid_i) st_q <= SqEmit;
                    SqEmit: begin
                        if (!idx_ok) begin
                            st_q <= SqTerminalError;
                        end else if (!state_valid_i) begin
                            st_q <= SqWaitState;
                        end else if (hs) begin
                            rem_q <= rem_q - OutLenW'(1);
                            idx_q <= run_o ? 6'd0 : idx_q + 6'd1;
                            if (last_hs)    st_q <= SqDone;
                            else if (run_o) st_q <= SqWaitRun;
                        end
                    end
                    SqWaitRun:       if (block_processed_i) st_q <= SqWaitState;
                    SqDone:          st_q <= SqIdle;
                    SqTerminalError: st_q <= SqTerminalError;
                    default:         st_q <= SqTerminalError;
                endcase
            end
        end
    end

    sha3_squeeze_ctrl_word_sel #(
        .Share (Share)
    ) u_word_sel (
        .state_i (state_i),
        .idx_i   (idx_q),
        .en_i    (digest_valid_o),
        .word_o  (digest_data_o)
    );

endmodule
